ifu_fetch_ctrl: RTL and testbench
=================================

# ifu_fetch_ctrl

Sequencing controller for the IFU program counter. It turns each PC update pulse into one instruction-memory read over a valid/ready address/data bus. It presents the returned word to ID through a valid/ready handshake and drives the PC counter's stall input so the PC advances only on a completed handoff or a branch redirect. It sits between the PC counter, the instruction bus and the IF/ID boundary, and keeps a delivered-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of the delivered-instruction counter

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- pc_i  input  32  current PC from the PC counter
- pc_change_i  input  1  PC-updated pulse from the PC counter; high in the first cycle after reset
- flush_i  input  1  branch redirect (BRANCH_PCSrc); the current or in-flight fetch is wrong-path
- ar_valid_o  output  1  read-address valid
- ar_ready_i  input  1  read-address accepted
- ar_addr_o  output  32  read address
- r_valid_i  input  1  read-data valid
- r_ready_o  output  1  read-data ready
- r_data_i  input  32  read data
- r_resp_i  input  2  read response; non-zero means error
- inst_valid_o  output  1  instruction valid to ID
- inst_ready_i  input  1  ID accepts the instruction
- inst_o  output  32  instruction word
- inst_pc_o  output  32  PC of inst_o
- inst_fault_o  output  2  fault code: 00 ok, 01 bus error, 10 misaligned PC
- stall_if_o  output  1  to PC counter FORWARD_stallIF
- inst_cnt_o  output  CNT_W  count of completed handoffs, wraps

## Operation
- States: IDLE, ADDR, DATA, HOLD. Registers:
  - req_pc (32)
  - pend: a PC pulse is waiting
  - discard: the in-flight response is wrong-path
- **IDLE**
  - Start condition: (pc_change_i | pend) & ~flush_i.
  - On start, latch req_pc <= pc_i and clear pend.
  - If pc_i[1:0] != 0, go to HOLD with inst_o=0x00000013, inst_fault_o=10, inst_pc_o=pc_i. No bus access is issued.
  - Otherwise go to ADDR.
- **ADDR**
  - ar_valid_o=1 and ar_addr_o=req_pc.
  - On ar_ready_i, go to DATA.
  - ar_valid_o is never retracted before ar_ready_i, including when flush_i is high.
- **DATA**
  - r_ready_o=1.
  - On r_valid_i with discard or flush_i high: drop the data, clear discard, go to IDLE.
  - On r_valid_i otherwise: latch inst_o=r_data_i, inst_pc_o=req_pc, and inst_fault_o=01 if r_resp_i!=0 else 00. Go to HOLD.
- **HOLD**
  - inst_valid_o=1; the inst_* outputs are stable.
  - On inst_ready_i & ~flush_i: handoff, inst_cnt_o += 1, go to IDLE.
  - On flush_i: drop the instruction, no count, go to IDLE. ID is flushed by the same signal.
- **flush_i handling**
  - flush_i in ADDR or DATA (without a same-cycle r_valid_i) sets discard.
  - flush_i in IDLE: no effect on state.
- **pend**
  - Set when pc_change_i=1 while state != IDLE.
  - Set when pc_change_i=1 in IDLE coincident with flush_i.
- **stall_if_o**
  - stall_if_o = ~(flush_i | (HOLD & inst_ready_i)), combinational.
  - It is low for exactly the handoff or redirect cycle, so the PC counter (where stall overrides branch) loads the branch target or pc+4.
  - Forced to 1 while rst is high.
- **Counter**
  - inst_cnt_o wraps from 2^CNT_W-1 to 0.
  - Misaligned-fault instructions count on handoff like any other.

## Timing
- Reset values (synchronous):
  - state=IDLE, pend=0, discard=0, req_pc=0
  - ar_valid_o=0, r_ready_o=0, inst_valid_o=0
  - inst_o=0, inst_pc_o=0, inst_fault_o=00, inst_cnt_o=0
- Reset mid-transaction abandons the bus request; the bus slave is reset by the same rst.
- ar_valid_o, r_ready_o and inst_valid_o are state decodes and carry no input-to-output combinational path. stall_if_o is the only combinational output.
- Best-case latency, with ar_ready_i and r_valid_i each high on the first cycle offered:
  - Cycle 0: pc_change_i seen in IDLE.
  - Cycle 1: ADDR, request accepted.
  - Cycle 2: DATA, data received.
  - Cycle 3: HOLD, inst_valid_o high.
  - If inst_ready_i is high in cycle 3, stall_if_o is low, the PC updates at the end of cycle 3, and pc_change_i is high in cycle 4.
  - Peak throughput: 1 instruction per 4 cycles.
- Simultaneous events:
  - flush_i with the r_valid_i beat: the beat is dropped.
  - flush_i with inst_ready_i in HOLD: flush wins and there is no count.
  - pc_change_i in the cycle after a flush while busy: captured in pend and issued from IDLE after the discarded response returns.

## Test plan
- **Basic fetch.** After rst release: pc_i=0x80000000, pc_change_i=1, ar_ready_i=1, then r_valid_i=1 with r_data_i=0x00100093, inst_ready_i=1. Required:
  - ar_addr_o=0x80000000 in cycle 1.
  - inst_valid_o=1 in cycle 3 with inst_o=0x00100093 and inst_pc_o=0x80000000.
  - stall_if_o=0 only in cycle 3.
  - inst_cnt_o=1.
- **Backpressure.** ar_ready_i is held low 3 cycles, then inst_ready_i is held low 4 cycles. Required:
  - ar_valid_o and ar_addr_o are stable throughout.
  - inst_* outputs are stable throughout.
  - stall_if_o=1 until the handoff cycle.
- **Flush in DATA.** flush_i pulses in DATA; r_valid_i arrives 2 cycles later; pc_change_i arrives with pc_i=0x80000100. Required:
  - stall_if_o=0 during the flush cycle.
  - The stale beat is dropped with no inst_valid_o.
  - The next ar_addr_o is 0x80000100.
- **Bus error.** r_resp_i=2'b10 is returned. Required: inst_valid_o=1 with inst_fault_o=01, and the count increments on handoff.
- **Misaligned PC.** pc_i=0x80000002 with pc_change_i=1. Required:
  - ar_valid_o is never asserted.
  - HOLD is reached with inst_o=0x00000013 and inst_fault_o=10.
- **Wrap and reset.** With CNT_W=4, run 16 handoffs, then assert rst while in ADDR. Required:
  - inst_cnt_o goes 15 to 0 on the 16th handoff.
  - rst clears all outputs in the next cycle.
  - ar_valid_o=0 while rst is high.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch sequencer: one instruction-bus read per PC update, handed to ID over valid/ready.
// Drives the PC counter stall so the PC moves only on a handoff or a branch redirect.
module ifu_fetch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_i,
  input  logic             pc_change_i,
  input  logic             flush_i,
  output logic             ar_valid_o,
  input  logic             ar_ready_i,
  output logic [31:0]      ar_addr_o,
  input  logic             r_valid_i,
  output logic             r_ready_o,
  input  logic [31:0]      r_data_i,
  input  logic [1:0]       r_resp_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_pc_o,
  output logic [1:0]       inst_fault_o,
  output logic             stall_if_o,
  output logic [CNT_W-1:0] inst_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t           state_r;
  logic [31:0]      req_pc_r;
  logic             pend_r;
  logic             discard_r;
  logic             ar_valid_r;
  logic             r_ready_r;
  logic             inst_valid_r;
  logic [31:0]      inst_r;
  logic [31:0]      inst_pc_r;
  logic [1:0]       inst_fault_r;
  logic [CNT_W-1:0] inst_cnt_r;
  logic             start_s;
  logic             stall_s;

  // Fetch start decision and the PC-counter stall, low only on handoff or redirect.
  always_comb begin
    start_s = (pc_change_i | pend_r) & ~flush_i;
    if (rst) begin
      stall_s = 1'b1;
    end else begin
      stall_s = ~(flush_i | ((state_r == HOLD) & inst_ready_i));
    end
  end

  // Fetch FSM with registered bus/ID handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_pc_r     <= 32'h0000_0000;
      pend_r       <= 1'b0;
      discard_r    <= 1'b0;
      ar_valid_r   <= 1'b0;
      r_ready_r    <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= 32'h0000_0000;
      inst_fault_r <= 2'b00;
      inst_cnt_r   <= '0;
    end else begin
      // A PC pulse arriving while busy is remembered and issued from IDLE later.
      if (pc_change_i && (state_r != IDLE)) begin
        pend_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            pend_r   <= 1'b0;
            req_pc_r <= pc_i;
            if (pc_i[1:0] != 2'b00) begin
              inst_r       <= NOP_INST;
              inst_pc_r    <= pc_i;
              inst_fault_r <= 2'b10;
              inst_valid_r <= 1'b1;
              state_r      <= HOLD;
            end else begin
              ar_valid_r <= 1'b1;
              state_r    <= ADDR;
            end
          end else if (pc_change_i) begin
            pend_r <= 1'b1;
          end
        end
        ADDR: begin
          // The request stays up until accepted; a flush only marks the reply stale.
          if (flush_i) begin
            discard_r <= 1'b1;
          end
          if (ar_ready_i) begin
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b1;
            state_r    <= DATA;
          end
        end
        DATA: begin
          if (r_valid_i) begin
            r_ready_r <= 1'b0;
            if (discard_r || flush_i) begin
              discard_r <= 1'b0;
              state_r   <= IDLE;
            end else begin
              inst_r       <= r_data_i;
              inst_pc_r    <= req_pc_r;
              inst_fault_r <= (r_resp_i != 2'b00) ? 2'b01 : 2'b00;
              inst_valid_r <= 1'b1;
              state_r      <= HOLD;
            end
          end else if (flush_i) begin
            discard_r <= 1'b1;
          end
        end
        HOLD: begin
          if (flush_i) begin
            inst_valid_r <= 1'b0;
            state_r      <= IDLE;
          end else if (inst_ready_i) begin
            inst_valid_r <= 1'b0;
            inst_cnt_r   <= inst_cnt_r + CNT_W'(1);
            state_r      <= IDLE;
          end
        end
        default: begin
          ar_valid_r   <= 1'b0;
          r_ready_r    <= 1'b0;
          inst_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign ar_valid_o   = ar_valid_r;
  assign ar_addr_o    = req_pc_r;
  assign r_ready_o    = r_ready_r;
  assign inst_valid_o = inst_valid_r;
  assign inst_o       = inst_r;
  assign inst_pc_o    = inst_pc_r;
  assign inst_fault_o = inst_fault_r;
  assign inst_cnt_o   = inst_cnt_r;
  assign stall_if_o   = stall_s;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a 4-bit counter so wrap is reachable quickly.
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_change_i;
  logic        flush_i;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [31:0] ar_addr_o;
  logic        r_valid_i;
  logic        r_ready_o;
  logic [31:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [1:0]  inst_fault_o;
  logic        stall_if_o;
  logic [3:0]  inst_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_cnt = 4'd0;

  ifu_fetch_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_change_i(pc_change_i), .flush_i(flush_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o), .stall_if_o(stall_if_o),
    .inst_cnt_o(inst_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    pc_change_i  = 1'b0;
    flush_i      = 1'b0;
    ar_ready_i   = 1'b0;
    r_valid_i    = 1'b0;
    inst_ready_i = 1'b0;
    r_resp_i     = 2'b00;
  endtask

  // Best-case fetch from IDLE: ADDR in cycle 1, DATA in 2, HOLD/handoff in 3.
  task automatic fetch_ok(input logic [31:0] pc, input logic [31:0] data,
                          input logic [1:0] resp, input logic [1:0] fault);
    pc_i = pc; pc_change_i = 1'b1; ar_ready_i = 1'b1; r_valid_i = 1'b1;
    r_data_i = data; r_resp_i = resp; inst_ready_i = 1'b1; flush_i = 1'b0;
    #1;
    chk("c0_stall", stall_if_o, 32'd1);
    chk("c0_arvalid", ar_valid_o, 32'd0);
    tick(); pc_change_i = 1'b0; #1;
    chk("c1_arvalid", ar_valid_o, 32'd1);
    chk("c1_araddr", ar_addr_o, pc);
    chk("c1_stall", stall_if_o, 32'd1);
    tick(); #1;
    chk("c2_rready", r_ready_o, 32'd1);
    chk("c2_ivalid", inst_valid_o, 32'd0);
    chk("c2_stall", stall_if_o, 32'd1);
    tick(); #1;
    chk("c3_ivalid", inst_valid_o, 32'd1);
    chk("c3_inst", inst_o, data);
    chk("c3_ipc", inst_pc_o, pc);
    chk("c3_fault", {30'd0, inst_fault_o}, {30'd0, fault});
    chk("c3_stall", stall_if_o, 32'd0);
    tick(); exp_cnt = exp_cnt + 4'd1; #1;
    chk("c4_ivalid", inst_valid_o, 32'd0);
    chk("c4_cnt", {28'd0, inst_cnt_o}, {28'd0, exp_cnt});
    chk("c4_stall", stall_if_o, 32'd1);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; pc_i = 32'h0; r_data_i = 32'h0;
    idle_inputs();
    #1;
    chk("rst_stall", stall_if_o, 32'd1);
    tick(); tick();
    chk("rst_arvalid", ar_valid_o, 32'd0);
    rst = 1'b0; #1;
    chk("reset_ivalid", inst_valid_o, 32'd0);
    chk("reset_rready", r_ready_o, 32'd0);
    chk("reset_inst", inst_o, 32'd0);
    chk("reset_ipc", inst_pc_o, 32'd0);
    chk("reset_fault", {30'd0, inst_fault_o}, 32'd0);
    chk("reset_cnt", {28'd0, inst_cnt_o}, 32'd0);
    chk("reset_stall", stall_if_o, 32'd1);

    // Basic fetch
    fetch_ok(32'h8000_0000, 32'h0010_0093, 2'b00, 2'b00);

    // Backpressure on address then on ID
    pc_i = 32'h8000_0004; pc_change_i = 1'b1; ar_ready_i = 1'b0;
    tick(); pc_change_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_arvalid", ar_valid_o, 32'd1);
      chk("bp_araddr", ar_addr_o, 32'h8000_0004);
      chk("bp_astall", stall_if_o, 32'd1);
      tick();
    end
    ar_ready_i = 1'b1; #1;
    chk("bp_arvalid_acc", ar_valid_o, 32'd1);
    tick(); ar_ready_i = 1'b0; r_valid_i = 1'b1; r_data_i = 32'h0020_8113;
    tick(); r_valid_i = 1'b0; r_data_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ivalid", inst_valid_o, 32'd1);
      chk("bp_inst", inst_o, 32'h0020_8113);
      chk("bp_ipc", inst_pc_o, 32'h8000_0004);
      chk("bp_istall", stall_if_o, 32'd1);
      tick();
    end
    inst_ready_i = 1'b1; #1;
    chk("bp_hand_stall", stall_if_o, 32'd0);
    tick(); exp_cnt = exp_cnt + 4'd1; inst_ready_i = 1'b0; #1;
    chk("bp_cnt", {28'd0, inst_cnt_o}, {28'd0, exp_cnt});

    // Flush in DATA, new PC captured while the stale beat is outstanding
    pc_i = 32'h8000_0008; pc_change_i = 1'b1; ar_ready_i = 1'b1;
    tick(); pc_change_i = 1'b0;
    tick(); ar_ready_i = 1'b0; flush_i = 1'b1; #1;
    chk("fl_rready", r_ready_o, 32'd1);
    chk("fl_stall", stall_if_o, 32'd0);
    tick(); flush_i = 1'b0; pc_i = 32'h8000_0100; pc_change_i = 1'b1; #1;
    chk("fl_stall_after", stall_if_o, 32'd1);
    tick(); pc_change_i = 1'b0; r_valid_i = 1'b1; r_data_i = 32'hBAD0_BAD0; #1;
    chk("fl_stale_rready", r_ready_o, 32'd1);
    tick(); r_valid_i = 1'b0; #1;
    chk("fl_no_ivalid", inst_valid_o, 32'd0);
    chk("fl_idle_arvalid", ar_valid_o, 32'd0);
    tick(); #1;
    chk("fl_next_arvalid", ar_valid_o, 32'd1);
    chk("fl_next_araddr", ar_addr_o, 32'h8000_0100);
    chk("fl_next_ivalid", inst_valid_o, 32'd0);
    ar_ready_i = 1'b1;
    tick(); ar_ready_i = 1'b0; r_valid_i = 1'b1; r_data_i = 32'h0030_0193;
    tick(); r_valid_i = 1'b0; inst_ready_i = 1'b1; #1;
    chk("fl_new_ivalid", inst_valid_o, 32'd1);
    chk("fl_new_inst", inst_o, 32'h0030_0193);
    chk("fl_new_ipc", inst_pc_o, 32'h8000_0100);
    tick(); exp_cnt = exp_cnt + 4'd1; inst_ready_i = 1'b0; #1;
    chk("fl_cnt", {28'd0, inst_cnt_o}, {28'd0, exp_cnt});

    // Bus error response
    fetch_ok(32'h8000_0104, 32'hDEAD_BEEF, 2'b10, 2'b01);

    // Misaligned PC: no bus access, NOP with fault 10
    pc_i = 32'h8000_0002; pc_change_i = 1'b1; ar_ready_i = 1'b1; #1;
    chk("mis_c0_arvalid", ar_valid_o, 32'd0);
    tick(); pc_change_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("mis_arvalid", ar_valid_o, 32'd0);
      chk("mis_ivalid", inst_valid_o, 32'd1);
      chk("mis_inst", inst_o, 32'h0000_0013);
      chk("mis_fault", {30'd0, inst_fault_o}, 32'd2);
      chk("mis_ipc", inst_pc_o, 32'h8000_0002);
      tick();
    end
    inst_ready_i = 1'b1; #1;
    chk("mis_stall", stall_if_o, 32'd0);
    tick(); exp_cnt = exp_cnt + 4'd1; idle_inputs(); #1;
    chk("mis_cnt", {28'd0, inst_cnt_o}, {28'd0, exp_cnt});
    chk("mis_arvalid_end", ar_valid_o, 32'd0);

    // Flush coincident with inst_ready in HOLD: flush wins, no count
    pc_i = 32'h8000_0200; pc_change_i = 1'b1; ar_ready_i = 1'b1; r_valid_i = 1'b1;
    r_data_i = 32'h0040_0213;
    tick(); pc_change_i = 1'b0;
    tick(); tick(); #1;
    chk("fh_ivalid", inst_valid_o, 32'd1);
    flush_i = 1'b1; inst_ready_i = 1'b1; #1;
    chk("fh_stall", stall_if_o, 32'd0);
    tick(); idle_inputs(); #1;
    chk("fh_ivalid_after", inst_valid_o, 32'd0);
    chk("fh_cnt", {28'd0, inst_cnt_o}, {28'd0, exp_cnt});

    // Sixteen handoffs: the 4-bit counter passes 15 -> 0 along the way
    for (int i = 0; i < 16; i++) begin
      fetch_ok(32'h8000_1000 + 32'(i) * 32'd4, 32'h0050_0293 + 32'(i), 2'b00, 2'b00);
    end

    // Reset asserted while in ADDR
    pc_i = 32'h8000_2000; pc_change_i = 1'b1; ar_ready_i = 1'b0;
    tick(); pc_change_i = 1'b0; #1;
    chk("rs_addr_arvalid", ar_valid_o, 32'd1);
    rst = 1'b1; #1;
    chk("rs_stall", stall_if_o, 32'd1);
    tick(); #1;
    chk("rs_arvalid", ar_valid_o, 32'd0);
    chk("rs_araddr", ar_addr_o, 32'd0);
    chk("rs_ivalid", inst_valid_o, 32'd0);
    chk("rs_rready", r_ready_o, 32'd0);
    chk("rs_inst", inst_o, 32'd0);
    chk("rs_ipc", inst_pc_o, 32'd0);
    chk("rs_fault", {30'd0, inst_fault_o}, 32'd0);
    chk("rs_cnt", {28'd0, inst_cnt_o}, 32'd0);
    tick(); #1;
    chk("rs_arvalid_hold", ar_valid_o, 32'd0);
    rst = 1'b0; exp_cnt = 4'd0;
    tick();
    fetch_ok(32'h8000_3000, 32'h0060_0313, 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
